// File: rtl/cube_physics.sv
// Per-frame motion engine for the player cube: horizontal move, jump, gravity,
// landing on the four floor rectangles, death line and restart.
module cube_physics #(
    parameter int CUBE     = 20,
    parameter int FLOOR_W  = 40,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int SPAWN_X  = 130,
    parameter int SPAWN_Y  = 400,
    parameter int X_STEP   = 2,
    parameter int JUMP_V   = 10,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        jump_btn,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        restart,
    input  logic [10:0] floor_pos_x0,
    input  logic [10:0] floor_pos_x1,
    input  logic [10:0] floor_pos_x2,
    input  logic [10:0] floor_pos_x3,
    input  logic [10:0] floor_pos_y0,
    input  logic [10:0] floor_pos_y1,
    input  logic [10:0] floor_pos_y2,
    input  logic [10:0] floor_pos_y3,
    input  logic [3:0]  floor_en,
    output logic [10:0] cube_x,
    output logic [10:0] cube_y,
    output logic [1:0]  state,
    output logic        landed,
    output logic [1:0]  land_idx,
    output logic        dead
);

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_RISING   = 2'd1,
        ST_FALLING  = 2'd2,
        ST_DEAD     = 2'd3
    } state_t;

    localparam logic signed [11:0] L_CUBE     = 12'(CUBE);
    localparam logic signed [11:0] L_FLOOR_W  = 12'(FLOOR_W);
    localparam logic signed [11:0] L_XMAX     = 12'(SCREEN_W - CUBE);
    localparam logic signed [11:0] L_SCREEN_H = 12'(SCREEN_H);
    localparam logic signed [11:0] L_XSTEP    = 12'(X_STEP);
    localparam logic signed [7:0]  L_JUMP_V   = 8'(JUMP_V);
    localparam logic signed [7:0]  L_GRAV     = 8'(GRAVITY);
    localparam logic signed [7:0]  L_MAX_FALL = 8'(MAX_FALL);

    function automatic logic signed [11:0] ext11(input logic [10:0] v);
        return signed'({1'b0, v});
    endfunction

    function automatic logic signed [11:0] sx8(input logic signed [7:0] v);
        return signed'({{4{v[7]}}, v});
    endfunction

    logic [10:0]        r_x;
    logic [10:0]        r_y;
    logic signed [7:0]  r_vy;
    state_t             r_state;
    logic               r_landed;
    logic [1:0]         r_land_idx;
    logic               r_dead;
    logic               r_jump_prev;
    logic               r_jump_pending;

    logic [10:0]        w_fx [4];
    logic [10:0]        w_fy [4];
    logic signed [11:0] w_cx;
    logic signed [11:0] w_cy;
    logic               w_jump_edge;
    logic               w_jump;
    logic signed [11:0] w_dx;
    logic signed [11:0] w_nx_raw;
    logic [10:0]        w_nx;
    logic signed [11:0] w_ny_rise;
    logic signed [7:0]  w_vy_rise;
    logic signed [7:0]  w_vy_inc;
    logic signed [7:0]  w_vy_fall;
    logic signed [11:0] w_ny_fall;
    logic [3:0]         w_overlap;
    logic [3:0]         w_cand;
    logic               w_support;
    logic               w_found;
    logic [1:0]         w_best_idx;
    logic [10:0]        w_best_fy;
    logic [10:0]        w_land_y;

    assign w_fx[0] = floor_pos_x0;
    assign w_fx[1] = floor_pos_x1;
    assign w_fx[2] = floor_pos_x2;
    assign w_fx[3] = floor_pos_x3;
    assign w_fy[0] = floor_pos_y0;
    assign w_fy[1] = floor_pos_y1;
    assign w_fy[2] = floor_pos_y2;
    assign w_fy[3] = floor_pos_y3;

    assign w_cx        = ext11(r_x);
    assign w_cy        = ext11(r_y);
    // An edge arriving together with the tick is honoured on that same tick.
    assign w_jump_edge = jump_btn & ~r_jump_prev;
    assign w_jump      = r_jump_pending | w_jump_edge;

    assign w_nx_raw  = w_cx + w_dx;
    assign w_ny_rise = w_cy + sx8(r_vy);
    assign w_vy_rise = r_vy + L_GRAV;
    assign w_vy_inc  = r_vy + L_GRAV;
    assign w_vy_fall = (w_vy_inc > L_MAX_FALL) ? L_MAX_FALL : w_vy_inc;
    assign w_ny_fall = w_cy + sx8(w_vy_fall);
    assign w_land_y  = w_best_fy - 11'(CUBE);

    always_comb begin
        case ({move_right, move_left})
            2'b10:   w_dx = L_XSTEP;
            2'b01:   w_dx = -L_XSTEP;
            default: w_dx = '0;
        endcase
        if (w_nx_raw < 12'sd0)
            w_nx = '0;
        else if (w_nx_raw > L_XMAX)
            w_nx = L_XMAX[10:0];
        else
            w_nx = w_nx_raw[10:0];
    end

    // Scan in index order with strict '<' so the lowest index wins equal tops.
    always_comb begin
        w_overlap  = '0;
        w_cand     = '0;
        w_support  = 1'b0;
        w_found    = 1'b0;
        w_best_idx = '0;
        w_best_fy  = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_overlap[i] = floor_en[i]
                         && (w_cx + L_CUBE > ext11(w_fx[i]))
                         && (w_cx < ext11(w_fx[i]) + L_FLOOR_W);
            w_cand[i]    = w_overlap[i]
                         && (w_cy + L_CUBE <= ext11(w_fy[i]))
                         && (w_ny_fall + L_CUBE >= ext11(w_fy[i]));
            if (w_overlap[i] && (w_cy + L_CUBE == ext11(w_fy[i])))
                w_support = 1'b1;
            if (w_cand[i] && (!w_found || (w_fy[i] < w_best_fy))) begin
                w_found    = 1'b1;
                w_best_idx = 2'(i);
                w_best_fy  = w_fy[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x            <= 11'(SPAWN_X);
            r_y            <= 11'(SPAWN_Y);
            r_vy           <= '0;
            r_state        <= ST_FALLING;
            r_landed       <= 1'b0;
            r_land_idx     <= '0;
            r_dead         <= 1'b0;
            r_jump_prev    <= 1'b0;
            r_jump_pending <= 1'b0;
        end else begin
            r_jump_prev    <= jump_btn;
            r_landed       <= 1'b0;
            r_jump_pending <= frame_tick ? 1'b0 : w_jump;
            if (r_state == ST_DEAD) begin
                if (restart) begin
                    r_x            <= 11'(SPAWN_X);
                    r_y            <= 11'(SPAWN_Y);
                    r_vy           <= '0;
                    r_state        <= ST_FALLING;
                    r_land_idx     <= '0;
                    r_dead         <= 1'b0;
                    r_jump_pending <= 1'b0;
                end
            end else if (frame_tick) begin
                r_x <= w_nx;
                case (r_state)
                    ST_GROUNDED: begin
                        if (w_jump) begin
                            r_vy    <= -L_JUMP_V;
                            r_state <= ST_RISING;
                        end else if (!w_support) begin
                            r_vy    <= '0;
                            r_state <= ST_FALLING;
                        end
                    end
                    ST_RISING: begin
                        if (w_ny_rise < 12'sd0) begin
                            r_y     <= '0;
                            r_vy    <= '0;
                            r_state <= ST_FALLING;
                        end else begin
                            r_y  <= w_ny_rise[10:0];
                            r_vy <= w_vy_rise;
                            if (!w_vy_rise[7])
                                r_state <= ST_FALLING;
                        end
                    end
                    ST_FALLING: begin
                        if (w_found) begin
                            r_y        <= w_land_y;
                            r_vy       <= '0;
                            r_state    <= ST_GROUNDED;
                            r_landed   <= 1'b1;
                            r_land_idx <= w_best_idx;
                        end else if (w_ny_fall + L_CUBE >= L_SCREEN_H) begin
                            r_y     <= w_ny_fall[10:0];
                            r_state <= ST_DEAD;
                            r_dead  <= 1'b1;
                        end else begin
                            r_y  <= w_ny_fall[10:0];
                            r_vy <= w_vy_fall;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cube_x   = r_x;
    assign cube_y   = r_y;
    assign state    = r_state;
    assign landed   = r_landed;
    assign land_idx = r_land_idx;
    assign dead     = r_dead;

endmodule
